aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Parametrised round-sequencing FSM for the AES core, successor to the fixed AES-128 controller. It supports AES-128/192/256 (10/12/14 rounds), encrypt and decrypt direction, and a handshake with the key-expansion unit. It also exports round number and round-key index, and supports abort. It sits between the top-level command interface and the round datapath / key schedule.

## Interface
- ROUND_W, 4, width of round counter and key index (must hold 14)
- iClk  input  1  clock, all logic on rising edge
- iRsn  input  1  reset, synchronous, active-low
- iStAes  input  1  start request, sampled only in IDLE
- iKeyLen  input  2  key length: 2'b00=128, 2'b01=192, 2'b10=256, 2'b11 illegal
- iDecrypt  input  1  direction, 1=decrypt; latched with start
- iKeyRdy  input  1  key expansion complete
- iAbort  input  1  abandon current operation
- iStall  input  1  datapath hold (present only with AES_CTRL_STALL_EN)
- oBusy  output  1  high in every state except IDLE
- oAesDone  output  1  one-cycle pulse in DONE
- oErr  output  1  one-cycle pulse on start with illegal iKeyLen
- oInitRoundFlag / oFstRoundFlag / oMidRoundFlag / oLstRoundFlag  output  1 each  state decodes
- oRoundEn  output  1  datapath register enable for current round
- oRoundNum  output  ROUND_W  current round, 0..Nr
- oKeyIdx  output  ROUND_W  round-key index to key schedule
- oDecrypt  output  1  latched direction

## Operation
- States: IDLE, WAIT_KEY, INIT, FST, MID, LST, DONE.
- IDLE: iStAes=1 with legal iKeyLen → WAIT_KEY; latch Nr (10/12/14) and iDecrypt. iKeyLen=11 → stay IDLE, pulse oErr next cycle.
- WAIT_KEY → INIT when iKeyRdy=1, else hold.
- INIT (round 0) → FST (round 1) → MID (rounds 2..Nr-1).
- MID → LST when rRound==Nr-1.
- LST (round Nr) → DONE → IDLE.
- rRound: 0 in IDLE/WAIT_KEY/INIT. Increments on each advance from INIT/FST/MID. Cleared on DONE exit.
- oKeyIdx = rRound for encrypt, Nr−rRound for decrypt.
- iAbort=1 in any non-IDLE state → IDLE next cycle. Counter cleared, no oAesDone. iAbort has priority over all other inputs.
- iStAes while busy is ignored. iKeyLen/iDecrypt changes mid-operation have no effect.
- Reset values: state IDLE. All outputs 0, counters 0, latched Nr=10, oDecrypt=0.
- Reset asserted mid-operation → IDLE on that edge, no done pulse.

## Timing
- iStAes sampled high in cycle T, iKeyRdy high at T+1: INIT at T+2, FST at T+3, LST at T+Nr+2, oAesDone at T+Nr+3.
- Done offset is T+13 (128), T+15 (192), T+17 (256). Each iKeyRdy-low cycle in WAIT_KEY adds one.
- Flags, oRoundNum and oKeyIdx are registered-state decodes, valid in the same cycle as the state.
- oBusy falls the cycle after DONE; a new start is accepted in that IDLE cycle.

## Configuration
- AES_CTRL_STALL_EN defined: iStall port exists. iStall=1 in INIT..LST holds state and rRound, forces oRoundEn=0, and extends latency one cycle per stall cycle. iAbort overrides iStall.
- AES_CTRL_STALL_EN undefined: no iStall port. oRoundEn = OR of the four round flags. Latency is fixed as above.

## Structure
- Package aes_ctrl_pkg holds:
  - state encoding localparams
  - key-length codes
  - Nr constants 10/12/14
  - function to map key length to Nr
- One sub-module, aes_round_cnt, holds the round counter, latched Nr, terminal compare (rRound==Nr-1) and key-index mux (encrypt/decrypt).

## Test plan
- AES-128 encrypt, iKeyRdy tied high, iStAes at T → oAesDone at T+13. oKeyIdx 0..10 ascending. oMidRoundFlag high 8 cycles.
- AES-256 decrypt → oAesDone at T+17. oKeyIdx 14,13,…,0. oRoundNum 0..14.
- AES-192 with iKeyRdy low 3 cycles after start → oAesDone at T+18. oBusy high throughout.
- iKeyLen=2'b11 with iStAes → oErr pulse one cycle, oBusy stays 0, no done.
- iAbort in MID at round 5 → IDLE next cycle, oRoundNum=0, no oAesDone. Immediate restart completes normally.
- With AES_CTRL_STALL_EN, AES-128 with iStall high for 2 cycles in FST → oRoundEn low those cycles, oAesDone at T+15.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared encodings for the AES round controller: state codes, key-length codes, round counts.
// Optional datapath stall support is enabled with AES_CTRL_STALL_EN.
package aes_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_KEY = 3'd1;
  localparam logic [2:0] ST_INIT     = 3'd2;
  localparam logic [2:0] ST_FST      = 3'd3;
  localparam logic [2:0] ST_MID      = 3'd4;
  localparam logic [2:0] ST_LST      = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  typedef enum logic [2:0] {
    IDLE     = ST_IDLE,
    WAIT_KEY = ST_WAIT_KEY,
    INIT     = ST_INIT,
    FST      = ST_FST,
    MID      = ST_MID,
    LST      = ST_LST,
    DONE     = ST_DONE
  } ctrlState_t;

  localparam logic [1:0] KEY_128 = 2'b00;
  localparam logic [1:0] KEY_192 = 2'b01;
  localparam logic [1:0] KEY_256 = 2'b10;
  localparam logic [1:0] KEY_BAD = 2'b11;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  function automatic int nrOf(input logic [1:0] keyLen);
    case (keyLen)
      KEY_192: return NR_192;
      KEY_256: return NR_256;
      KEY_128: return NR_128;
      default: return NR_128;
    endcase
  endfunction

  function automatic logic keyLegal(input logic [1:0] keyLen);
    return keyLen != KEY_BAD;
  endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Command / datapath bus of the AES round controller.
// The iStall hold input exists only when AES_CTRL_STALL_EN is defined.
interface aes_round_ctrl_if #(parameter int ROUND_W = 4);

  logic               iStAes;
  logic [1:0]         iKeyLen;
  logic               iDecrypt;
  logic               iKeyRdy;
  logic               iAbort;
`ifdef AES_CTRL_STALL_EN
  logic               iStall;
`endif
  logic               oBusy;
  logic               oAesDone;
  logic               oErr;
  logic               oInitRoundFlag;
  logic               oFstRoundFlag;
  logic               oMidRoundFlag;
  logic               oLstRoundFlag;
  logic               oRoundEn;
  logic [ROUND_W-1:0] oRoundNum;
  logic [ROUND_W-1:0] oKeyIdx;
  logic               oDecrypt;

  modport slave (
    output oBusy, oAesDone, oErr, oInitRoundFlag, oFstRoundFlag, oMidRoundFlag,
           oLstRoundFlag, oRoundEn, oRoundNum, oKeyIdx, oDecrypt,
    input  iStAes, iKeyLen, iDecrypt, iKeyRdy, iAbort
`ifdef AES_CTRL_STALL_EN
    , input iStall
`endif
  );

  modport master (
    input  oBusy, oAesDone, oErr, oInitRoundFlag, oFstRoundFlag, oMidRoundFlag,
           oLstRoundFlag, oRoundEn, oRoundNum, oKeyIdx, oDecrypt,
    output iStAes, iKeyLen, iDecrypt, iKeyRdy, iAbort
`ifdef AES_CTRL_STALL_EN
    , output iStall
`endif
  );

endinterface

// File: rtl/aes_round_ctrl_cnt.sv
// Round counter with latched round count and direction, last-middle-round compare
// and the encrypt/decrypt round-key index mux.
module aes_round_cnt
  import aes_ctrl_pkg::*;
#(
  parameter int ROUND_W = 4
) (
  input  logic               iClk,
  input  logic               iRsn,
  input  logic               iLoad,
  input  logic [ROUND_W-1:0] iNr,
  input  logic               iDec,
  input  logic               iInc,
  input  logic               iClr,
  output logic [ROUND_W-1:0] oRound,
  output logic               oLastMid,
  output logic [ROUND_W-1:0] oKeyIdx,
  output logic               oDecrypt
);

  logic [ROUND_W-1:0] rRound;
  logic [ROUND_W-1:0] nrReg;
  logic               decReg;

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      rRound <= '0;
      nrReg  <= ROUND_W'(NR_128);
      decReg <= 1'b0;
    end else begin
      if (iLoad) begin
        nrReg  <= iNr;
        decReg <= iDec;
      end
      if (iClr)
        rRound <= '0;
      else if (iInc)
        rRound <= rRound + ROUND_W'(1);
    end
  end

  assign oRound   = rRound;
  assign oLastMid = (rRound == nrReg - ROUND_W'(1));
  // Decryption walks the key schedule backwards from the last round key.
  assign oKeyIdx  = decReg ? (nrReg - rRound) : rRound;
  assign oDecrypt = decReg;

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128/192/256 round sequencer with key-ready handshake, abort and error pulse.
// Define AES_CTRL_STALL_EN to add the iStall datapath hold.
module aes_round_ctrl
  import aes_ctrl_pkg::*;
#(
  parameter int ROUND_W = 4
) (
  input logic              iClk,
  input logic              iRsn,
  aes_round_ctrl_if.slave  bus
);

  ctrlState_t         stateReg, stateNext;
  logic               errReg, errNext;
  logic               cntLoad, cntInc, cntClr;
  logic               lastMid;
  logic               stall;
  logic               inRound;
  logic [ROUND_W-1:0] roundNum;
  logic [ROUND_W-1:0] keyIdx;
  logic               decLatched;

`ifdef AES_CTRL_STALL_EN
  assign stall = bus.iStall;
`else
  assign stall = 1'b0;
`endif

  aes_round_cnt #(.ROUND_W(ROUND_W)) uCnt (
    .iClk    (iClk),
    .iRsn    (iRsn),
    .iLoad   (cntLoad),
    .iNr     (ROUND_W'(nrOf(bus.iKeyLen))),
    .iDec    (bus.iDecrypt),
    .iInc    (cntInc),
    .iClr    (cntClr),
    .oRound  (roundNum),
    .oLastMid(lastMid),
    .oKeyIdx (keyIdx),
    .oDecrypt(decLatched)
  );

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      stateReg <= IDLE;
      errReg   <= 1'b0;
    end else begin
      stateReg <= stateNext;
      errReg   <= errNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    errNext   = 1'b0;
    cntLoad   = 1'b0;
    cntInc    = 1'b0;
    cntClr    = 1'b0;
    // Abort outranks every other input, including a stall.
    if (stateReg != IDLE && bus.iAbort) begin
      stateNext = IDLE;
      cntClr    = 1'b1;
    end else begin
      case (stateReg)
        IDLE: begin
          if (bus.iStAes) begin
            if (keyLegal(bus.iKeyLen)) begin
              stateNext = WAIT_KEY;
              cntLoad   = 1'b1;
              cntClr    = 1'b1;
            end else begin
              errNext = 1'b1;
            end
          end
        end
        WAIT_KEY: if (bus.iKeyRdy) stateNext = INIT;
        INIT: if (!stall) begin
          stateNext = FST;
          cntInc    = 1'b1;
        end
        FST: if (!stall) begin
          stateNext = MID;
          cntInc    = 1'b1;
        end
        MID: if (!stall) begin
          cntInc = 1'b1;
          if (lastMid) stateNext = LST;
        end
        LST: if (!stall) stateNext = DONE;
        DONE: begin
          stateNext = IDLE;
          cntClr    = 1'b1;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  assign bus.oInitRoundFlag = (stateReg == INIT);
  assign bus.oFstRoundFlag  = (stateReg == FST);
  assign bus.oMidRoundFlag  = (stateReg == MID);
  assign bus.oLstRoundFlag  = (stateReg == LST);
  assign inRound            = bus.oInitRoundFlag | bus.oFstRoundFlag |
                              bus.oMidRoundFlag  | bus.oLstRoundFlag;
  assign bus.oRoundEn       = inRound & ~stall;
  assign bus.oBusy          = (stateReg != IDLE);
  assign bus.oAesDone       = (stateReg == DONE);
  assign bus.oErr           = errReg;
  assign bus.oRoundNum      = roundNum;
  assign bus.oKeyIdx        = keyIdx;
  assign bus.oDecrypt       = decLatched;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomised self-checking bench for aes_round_ctrl against a cycle-trace reference model.
// Stall scenarios are exercised only when AES_CTRL_STALL_EN is defined.
module tb_aes_round_ctrl;

  logic iClk;
  logic iRsn;
  int   nTests;
  int   nFail;

  aes_round_ctrl_if #(.ROUND_W(4)) bus ();

  aes_round_ctrl #(.ROUND_W(4)) dut (
    .iClk(iClk),
    .iRsn(iRsn),
    .bus (bus)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected observation for one clock cycle of an operation.
  typedef struct {
    bit busy;
    bit done;
    bit fInit;
    bit fFst;
    bit fMid;
    bit fLst;
    bit roundEn;
    bit stall;
    bit keyRdy;
    int roundNum;
    int keyIdx;
  } exp_t;

  function automatic int nrFor(input int kl);
    return (kl == 0) ? 10 : (kl == 1) ? 12 : 14;
  endfunction

  // Start one operation in the current (idle) cycle and check every cycle up to DONE,
  // or up to the abort cycle when abortAt >= 0.
  task automatic run_op(input int kl, input bit dec, input int keyWait,
                        input int stallRound, input int stallLen, input int abortAt,
                        output int midCnt);
    exp_t q[$];
    exp_t e;
    int   nr;
    int   doneCyc;
    nr      = nrFor(kl);
    midCnt  = 0;
    doneCyc = -1;
    for (int j = 0; j <= keyWait; j++) begin
      e = '{default: 0};
      e.busy   = 1;
      e.keyRdy = (j == keyWait);
      e.keyIdx = dec ? nr : 0;
      q.push_back(e);
    end
    for (int r = 0; r <= nr; r++) begin
      e = '{default: 0};
      e.busy     = 1;
      e.fInit    = (r == 0);
      e.fFst     = (r == 1);
      e.fMid     = (r > 1) && (r < nr);
      e.fLst     = (r == nr);
      e.roundNum = r;
      e.keyIdx   = dec ? nr - r : r;
      if (r == stallRound) begin
        for (int s = 0; s < stallLen; s++) begin
          e.stall   = 1;
          e.roundEn = 0;
          q.push_back(e);
        end
      end
      e.stall   = 0;
      e.roundEn = 1;
      q.push_back(e);
    end
    e = '{default: 0};
    e.busy     = 1;
    e.done     = 1;
    e.roundNum = nr;
    e.keyIdx   = dec ? 0 : nr;
    q.push_back(e);

    // Start cycle T: controller must be idle with a cleared counter and no done.
    @(posedge iClk); #1;
    bus.iStAes   = 1'b1;
    bus.iKeyLen  = 2'(kl);
    bus.iDecrypt = dec;
    bus.iKeyRdy  = 1'($urandom);
    bus.iAbort   = 1'b0;
`ifdef AES_CTRL_STALL_EN
    bus.iStall   = 1'b0;
`endif
    @(negedge iClk);
    nTests++;
    if (bus.oBusy !== 1'b0 || bus.oAesDone !== 1'b0 || bus.oRoundNum !== 4'd0) begin
      nFail++;
      $display("[TB] FAIL start_idle: busy=%b done=%b round=%0d, required busy=0 done=0 round=0",
               bus.oBusy, bus.oAesDone, bus.oRoundNum);
    end

    for (int i = 0; i < q.size(); i++) begin
      @(posedge iClk); #1;
      bus.iStAes   = 1'($urandom);
      bus.iKeyLen  = 2'($urandom);
      bus.iDecrypt = 1'($urandom);
      bus.iKeyRdy  = (i <= keyWait) ? q[i].keyRdy : 1'($urandom);
      bus.iAbort   = (i == abortAt);
`ifdef AES_CTRL_STALL_EN
      bus.iStall   = q[i].stall;
`endif
      @(negedge iClk);
      e = q[i];
      nTests++;
      if (bus.oBusy !== e.busy || bus.oAesDone !== e.done || bus.oErr !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL status c%0d: busy=%b done=%b err=%b, required busy=%b done=%b err=0",
                 i + 1, bus.oBusy, bus.oAesDone, bus.oErr, e.busy, e.done);
      end
      nTests++;
      if ({bus.oInitRoundFlag, bus.oFstRoundFlag, bus.oMidRoundFlag, bus.oLstRoundFlag}
          !== {e.fInit, e.fFst, e.fMid, e.fLst} || bus.oRoundEn !== e.roundEn) begin
        nFail++;
        $display("[TB] FAIL flags c%0d: ifml=%b%b%b%b en=%b, required %b%b%b%b en=%b", i + 1,
                 bus.oInitRoundFlag, bus.oFstRoundFlag, bus.oMidRoundFlag, bus.oLstRoundFlag,
                 bus.oRoundEn, e.fInit, e.fFst, e.fMid, e.fLst, e.roundEn);
      end
      nTests++;
      if (int'(bus.oRoundNum) !== e.roundNum || int'(bus.oKeyIdx) !== e.keyIdx ||
          bus.oDecrypt !== dec) begin
        nFail++;
        $display("[TB] FAIL round c%0d: round=%0d key=%0d dec=%b, required round=%0d key=%0d dec=%b",
                 i + 1, bus.oRoundNum, bus.oKeyIdx, bus.oDecrypt, e.roundNum, e.keyIdx, dec);
      end
      if (bus.oMidRoundFlag === 1'b1) midCnt++;
      if (bus.oAesDone === 1'b1 && doneCyc < 0) doneCyc = i + 1;
      if (i == abortAt) begin
        $display("[TB] op kl=%0d dec=%0d wait=%0d aborted at T+%0d", kl, dec, keyWait, i + 1);
        return;
      end
    end
    nTests++;
    if (doneCyc !== 3 + nr + keyWait + stallLen) begin
      nFail++;
      $display("[TB] FAIL done_latency: done at T+%0d, required T+%0d",
               doneCyc, 3 + nr + keyWait + stallLen);
    end
    $display("[TB] op kl=%0d dec=%0d wait=%0d stall=%0d done at T+%0d",
             kl, dec, keyWait, stallLen, doneCyc);
  endtask

  task automatic test_reset();
    @(negedge iClk);
    nTests++;
    if (bus.oBusy !== 1'b0 || bus.oAesDone !== 1'b0 || bus.oErr !== 1'b0 ||
        bus.oRoundEn !== 1'b0 || bus.oRoundNum !== 4'd0 || bus.oKeyIdx !== 4'd0 ||
        bus.oDecrypt !== 1'b0 ||
        {bus.oInitRoundFlag, bus.oFstRoundFlag, bus.oMidRoundFlag, bus.oLstRoundFlag} !== 4'b0) begin
      nFail++;
      $display("[TB] FAIL reset_state: busy=%b done=%b err=%b en=%b round=%0d key=%0d dec=%b, required all 0",
               bus.oBusy, bus.oAesDone, bus.oErr, bus.oRoundEn, bus.oRoundNum, bus.oKeyIdx, bus.oDecrypt);
    end
    @(posedge iClk); #1;
    iRsn = 1'b1;
    @(negedge iClk);
    nTests++;
    if (bus.oBusy !== 1'b0 || bus.oRoundNum !== 4'd0) begin
      nFail++;
      $display("[TB] FAIL reset_release: busy=%b round=%0d, required 0 0", bus.oBusy, bus.oRoundNum);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_aes128_enc();
    int mids;
    run_op(0, 1'b0, 0, -1, 0, -1, mids);
    nTests++;
    if (mids !== 8) begin
      nFail++;
      $display("[TB] FAIL mid_cycles_128: %0d cycles, required 8", mids);
    end
  endtask

  task automatic test_aes256_dec();
    int mids;
    run_op(2, 1'b1, 0, -1, 0, -1, mids);
    nTests++;
    if (mids !== 12) begin
      nFail++;
      $display("[TB] FAIL mid_cycles_256: %0d cycles, required 12", mids);
    end
  endtask

  task automatic test_aes192_keywait();
    int mids;
    run_op(1, 1'b0, 3, -1, 0, -1, mids);
  endtask

  task automatic test_illegal_key();
    @(posedge iClk); #1;
    bus.iStAes  = 1'b1;
    bus.iKeyLen = 2'b11;
    bus.iAbort  = 1'b0;
    @(posedge iClk); #1;
    bus.iStAes  = 1'b0;
    bus.iKeyLen = 2'b00;
    @(negedge iClk);
    nTests++;
    if (bus.oErr !== 1'b1 || bus.oBusy !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL err_pulse: err=%b busy=%b, required err=1 busy=0", bus.oErr, bus.oBusy);
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge iClk);
      nTests++;
      if (bus.oErr !== 1'b0 || bus.oBusy !== 1'b0 || bus.oAesDone !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL err_after c%0d: err=%b busy=%b done=%b, required 0 0 0",
                 i, bus.oErr, bus.oBusy, bus.oAesDone);
      end
    end
    $display("[TB] illegal key length start checked");
  endtask

  task automatic test_abort_restart();
    int mids;
    // Round 5 of an AES-128 op with no key wait sits at trace index 1 + 5.
    run_op(0, 1'b0, 0, -1, 0, 6, mids);
    run_op(0, 1'b0, 0, -1, 0, -1, mids);
  endtask

  task automatic test_back_to_back();
    int mids;
    run_op(1, 1'b1, 0, -1, 0, -1, mids);
    run_op(2, 1'b0, 1, -1, 0, -1, mids);
  endtask

  task automatic test_reset_midop();
    bit hit;
    @(posedge iClk); #1;
    bus.iStAes   = 1'b1;
    bus.iKeyLen  = 2'b00;
    bus.iDecrypt = 1'b1;
    bus.iKeyRdy  = 1'b1;
    bus.iAbort   = 1'b0;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge iClk); #1;
      bus.iStAes = 1'b0;
      @(negedge iClk);
      if (bus.oRoundNum === 4'd5) hit = 1;
    end
    nTests++;
    if (!hit) begin
      nFail++;
      $display("[TB] FAIL reset_midop_reach: round 5 not reached, required within 40 cycles");
    end
    @(posedge iClk); #1;
    iRsn = 1'b0;
    @(posedge iClk); #1;
    iRsn = 1'b1;
    @(negedge iClk);
    nTests++;
    if (bus.oBusy !== 1'b0 || bus.oAesDone !== 1'b0 || bus.oRoundNum !== 4'd0 ||
        bus.oKeyIdx !== 4'd0 || bus.oDecrypt !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL reset_midop: busy=%b done=%b round=%0d key=%0d dec=%b, required all 0",
               bus.oBusy, bus.oAesDone, bus.oRoundNum, bus.oKeyIdx, bus.oDecrypt);
    end
    $display("[TB] reset during operation checked");
  endtask

`ifdef AES_CTRL_STALL_EN
  task automatic test_stall();
    int mids;
    run_op(0, 1'b0, 0, 1, 2, -1, mids);
  endtask
`endif

  task automatic test_random();
    int kl, wt, nr, total, ab, sr, sl, mids;
    bit dec;
    for (int n = 0; n < 16; n++) begin
      kl  = $urandom_range(0, 2);
      dec = 1'($urandom);
      wt  = $urandom_range(0, 3);
      nr  = nrFor(kl);
      sr  = -1;
      sl  = 0;
`ifdef AES_CTRL_STALL_EN
      sr  = $urandom_range(0, nr);
      sl  = $urandom_range(0, 2);
`endif
      total = wt + 1 + nr + 1 + sl + 1;
      ab = -1;
      if (n != 15 && $urandom_range(0, 3) == 0) ab = $urandom_range(0, total - 1);
      run_op(kl, dec, wt, sr, sl, ab, mids);
    end
  endtask

  initial begin
    nTests       = 0;
    nFail        = 0;
    iRsn         = 1'b0;
    bus.iStAes   = 1'b0;
    bus.iKeyLen  = 2'b00;
    bus.iDecrypt = 1'b0;
    bus.iKeyRdy  = 1'b0;
    bus.iAbort   = 1'b0;
`ifdef AES_CTRL_STALL_EN
    bus.iStall   = 1'b0;
`endif
    repeat (3) @(posedge iClk);
    test_reset();
    test_aes128_enc();
    test_aes256_dec();
    test_aes192_keywait();
    test_illegal_key();
    test_abort_restart();
    test_back_to_back();
    test_reset_midop();
`ifdef AES_CTRL_STALL_EN
    test_stall();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
